// File: rtl/rvm_bitwise_mc.sv
// Multi-cycle bitwise logic unit: one request at a time, the result is
// built SLICE bits per cycle (LSB slice first) and presented until taken.
module rvm_bitwise_mc #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_lhs,
  input  logic [XLEN-1:0] req_rhs,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result
);

  localparam int unsigned NSLICE = XLEN / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] lhs_q, lhs_d;
  logic [XLEN-1:0] rhs_q, rhs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] full_w;

  // Full-width function of the captured operands; only one slice is used per cycle.
  always_comb begin
    full_w = '0;
    case (op_q)
      OP_OR:   full_w = lhs_q | rhs_q;
      OP_AND:  full_w = lhs_q & rhs_q;
      OP_XOR:  full_w = lhs_q ^ rhs_q;
      OP_ANDN: full_w = lhs_q & ~rhs_q;
      OP_ORN:  full_w = lhs_q | ~rhs_q;
      OP_XNOR: full_w = ~(lhs_q ^ rhs_q);
      default: full_w = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, fill one slice per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && (req_op != OP_NOP)) begin
          op_d    = req_op;
          lhs_d   = req_lhs;
          rhs_d   = req_rhs;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Constant-indexed slice writes keep the part selects static.
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (cnt_q == CW'(i)) begin
            res_d[i*SLICE +: SLICE] = full_w[i*SLICE +: SLICE];
          end
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          res_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      lhs_q   <= '0;
      rhs_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      res_q   <= res_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_result = rsp_valid ? res_q : '0;

endmodule

// File: tb/tb_rvm_bitwise_mc.sv
// Bench for rvm_bitwise_mc: three builds (SLICE 8/32/4) share one stimulus
// stream and are each checked every cycle against a latency-count model.
module tb_rvm_bitwise_mc;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_lhs = '0;
  logic [31:0] req_rhs = '0;

  logic [2:0]  rdy;
  logic [2:0]  vld;
  logic [31:0] res [3];

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  rvm_bitwise_mc #(.XLEN(32), .SLICE(8)) u_s8 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_result(res[0]));
  rvm_bitwise_mc #(.XLEN(32), .SLICE(32)) u_s32 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_result(res[1]));
  rvm_bitwise_mc #(.XLEN(32), .SLICE(4)) u_s4 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs),
    .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_result(res[2]));

  int lat_cfg [3] = '{4, 1, 8};

  function automatic logic [31:0] f_op(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
    case (op)
      3'd1: return l | r;
      3'd2: return l & r;
      3'd3: return l ^ r;
      3'd4: return l & ~r;
      3'd5: return l | ~r;
      3'd6: return ~(l ^ r);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining cycles until the result is presented, plus done flag.
  int          m_rem  [3];
  logic        m_done [3];
  logic [31:0] m_res  [3];

  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 3; k++) begin
      if (!resetn) begin
        m_rem[k]  <= 0;
        m_done[k] <= 1'b0;
        m_res[k]  <= '0;
      end else if (m_done[k]) begin
        if (rsp_ready) m_done[k] <= 1'b0;
      end else if (m_rem[k] > 0) begin
        m_rem[k] <= m_rem[k] - 1;
        if (m_rem[k] == 1) m_done[k] <= 1'b1;
      end else if (req_valid && req_op != 3'd0) begin
        m_rem[k] <= lat_cfg[k];
        m_res[k] <= f_op(req_op, req_lhs, req_rhs);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("req_ready[%0d]", k), {31'd0, rdy[k]}, {31'd0, (m_rem[k] == 0) && !m_done[k]});
        chk($sformatf("rsp_valid[%0d]", k), {31'd0, vld[k]}, {31'd0, m_done[k]});
        chk($sformatf("rsp_result[%0d]", k), res[k], m_done[k] ? m_res[k] : 32'h0);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_ready"}, {31'd0, rdy[k]}, 32'd1);
      chk({tag, "_valid"}, {31'd0, vld[k]}, 32'd0);
      chk({tag, "_result"}, res[k], 32'h0);
    end
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (rdy != 3'b111 && n < 50) begin @(negedge clk); n++; end
    if (rdy != 3'b111) chk("timeout_ready", {29'd0, rdy}, 32'd7);
  endtask

  task automatic wait_all_done();
    int n = 0;
    while (vld != 3'b111 && n < 50) begin @(negedge clk); n++; end
    if (vld != 3'b111) chk("timeout_done", {29'd0, vld}, 32'd7);
  endtask

  task automatic handshake();
    @(negedge clk) rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
    wait_all_ready();
    req_valid = 1'b1; req_op = op; req_lhs = l; req_rhs = r;
    @(negedge clk) req_valid = 1'b0;
  endtask

  logic [2:0]  t_op  [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] t_exp [6] = '{32'h00FF_FFFF, 32'h00FF_FF00, 32'h0000_FF00,
                             32'hFF00_FFFF, 32'hFF00_00FF, 32'h0000_0000};

  initial begin
    int first [3];
    // Model pins: hand-computed values.
    chk("pin_and", f_op(3'd2, 32'hF0F0_1234, 32'hFF00_FFFF), 32'hF000_1234);
    for (int i = 0; i < 6; i++)
      chk($sformatf("pin_op%0d", t_op[i]), f_op(t_op[i], 32'h0000_FFFF, 32'h00FF_00FF), t_exp[i]);

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    chk_en = 1'b1;

    // Request presented as reset releases: accepted on the first edge.
    @(negedge clk);
    resetn = 1'b1;
    req_valid = 1'b1; req_op = 3'd2; req_lhs = 32'hF0F0_1234; req_rhs = 32'hFF00_FFFF;
    first = '{-1, -1, -1};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      for (int k = 0; k < 3; k++) if (first[k] < 0 && vld[k]) first[k] = c;
    end
    for (int k = 0; k < 3; k++) chk($sformatf("latency[%0d]", k), first[k], lat_cfg[k] + 1);

    // Backpressure: hold in DONE while req_* toggles.
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'(c & 1); req_op = 3'($urandom); req_lhs = $urandom; req_rhs = $urandom;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("bp_result", res[k], 32'hF000_1234);
        chk("bp_ready", {31'd0, rdy[k]}, 32'd0);
      end
    end
    req_valid = 1'b0;
    handshake();

    // Every op on the reference operands, all builds.
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], 32'h0000_FFFF, 32'h00FF_00FF);
      wait_all_done();
      for (int k = 0; k < 3; k++) chk($sformatf("op%0d_res[%0d]", t_op[i], k), res[k], t_exp[i]);
      handshake();
    end

    // NOP: stays idle, no response.
    req_valid = 1'b1; req_op = 3'd0; req_lhs = $urandom; req_rhs = $urandom;
    repeat (6) begin
      @(negedge clk);
      chk("nop_ready", {29'd0, rdy}, 32'd7);
      chk("nop_valid", {29'd0, vld}, 32'd0);
    end
    req_valid = 1'b0;

    // Reset while the SLICE=8 build is on slice 2 of an XOR.
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk) resetn = 1'b1;
    issue(3'd2, 32'hF0F0_1234, 32'hFF00_FFFF);
    wait_all_done();
    for (int k = 0; k < 3; k++) chk("post_rst_and", res[k], 32'hF000_1234);
    handshake();

    // Random traffic; the per-cycle model check does the work here.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_op    = 3'($urandom);
      req_lhs   = $urandom;
      req_rhs   = $urandom;
      rsp_ready = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rvm_bitwise_mc.md
RVM_BITWISE_MC -- requirements
Module: rvm_bitwise_mc

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 Parameter SLICE, default 8: bits processed per cycle; XLEN SHALL be an integer multiple of SLICE.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port resetn  input  1: reset, asynchronous and active-low.
REQ-005 Port req_valid  input  1: request present.
REQ-006 Port req_ready  output  1: unit can accept a request.
REQ-007 Port req_op  input  3: operation select.
REQ-008 Port req_lhs  input  XLEN: left-hand operand.
REQ-009 Port req_rhs  input  XLEN: right-hand operand.
REQ-010 Port rsp_valid  output  1: result available.
REQ-011 Port rsp_ready  input  1: consumer takes result.
REQ-012 Port rsp_result  output  XLEN: computed result.

Function
REQ-013 The unit SHALL implement the op encoding: 000 NOP, 001 OR, 010 AND, 011 XOR, 100 ANDN (lhs & ~rhs), 101 ORN (lhs | ~rhs), 110 XNOR, 111 reserved (result all-zero).
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 A request SHALL be accepted on a cycle where req_valid and req_ready are both high.
REQ-016 req_ready SHALL be high only in IDLE.
REQ-017 On acceptance of a non-NOP op, the unit SHALL capture op, lhs and rhs, clear the slice counter and the result register, and move IDLE->BUSY.
REQ-018 On acceptance of NOP, the unit SHALL remain in IDLE and generate no response.
REQ-019 In BUSY, each cycle SHALL compute one SLICE-bit slice, LSB slice first, and write it into the matching bits of the result register.
REQ-020 The counter SHALL run 0..XLEN/SLICE-1; after the slice at index XLEN/SLICE-1 is written, the FSM SHALL move BUSY->DONE.
REQ-021 rsp_valid SHALL be asserted exactly XLEN/SLICE cycles after the accepting edge (4 cycles at defaults).
REQ-022 In DONE, rsp_valid SHALL be high, and rsp_result SHALL hold the full result stable until the handshake.
REQ-023 A rsp_valid && rsp_ready cycle SHALL move DONE->IDLE, deassert rsp_valid on the next cycle, and zero the result register.
REQ-024 No new request SHALL be accepted in the same cycle as the response handshake; back-to-back throughput is one result per XLEN/SLICE+2 cycles.
REQ-025 rsp_result SHALL read all-zero whenever rsp_valid is low (operand isolation).
REQ-026 Changes on req_* while BUSY or DONE SHALL have no effect on the captured operation.
REQ-027 With SLICE equal to XLEN, BUSY SHALL last exactly one cycle.

Reset
REQ-028 While resetn is low, the unit SHALL be in IDLE, with the counter, captured operands and result register at zero; req_ready SHALL be 1, rsp_valid 0 and rsp_result 0.
REQ-029 Reset asserted in BUSY or DONE SHALL abort the operation immediately, and no response SHALL be produced for it.
REQ-030 After resetn deasserts, a request SHALL be accepted on the first rising edge with req_valid high.

Verification
REQ-031 AND: lhs=0xF0F0_1234, rhs=0xFF00_FFFF, op=010 -> rsp_valid 4 cycles after accept, result 0xF000_1234.
REQ-032 All ops: lhs=0x0000_FFFF, rhs=0x00FF_00FF -> OR 0x00FF_FFFF, XOR 0x00FF_FF00, ANDN 0x0000_FF00, ORN 0xFF00_FFFF, XNOR 0xFF00_00FF, 111 0x0000_0000.
REQ-033 Backpressure: hold rsp_ready low 10 cycles in DONE and toggle req_* -> rsp_result stable, req_ready low, no re-accept.
REQ-034 NOP: op=000 with req_valid high -> req_ready stays 1, rsp_valid never asserts.
REQ-035 Reset mid-op: assert resetn low at BUSY slice 2 of an XOR -> outputs return to reset values asynchronously; a following AND returns the correct result with no stale data.
REQ-036 Parameter sweep: SLICE=32 and SLICE=4 -> latency 1 and 8 cycles, results identical to the default build.
